// File: rtl/spm_dump_engine.sv
// Scratchpad readback engine: sweeps a word range and streams it out as little-endian bytes.
// Define SPM_DUMP_CHECKSUM_EN to append a 32-bit additive checksum (LS byte first).
module spm_dump_engine #(
  parameter int unsigned WORDS = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_start,
  input  logic [31:0] io_baseAddress,
  input  logic [31:0] io_wordCount,
  output logic [31:0] io_rdAddress,
  input  logic [31:0] io_rdData,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [7:0]  io_out_bits,
  output logic        io_busy,
  output logic        io_done,
  output logic        io_error
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLatch,
    StSend,
`ifdef SPM_DUMP_CHECKSUM_EN
    StCsum,
`endif
    StDone
  } state_t;

  state_t      stateQ, stateD;
  logic [31:0] addrQ, addrD;
  logic [31:0] rdAddrQ;
  logic [31:0] remQ, remD;
  logic [31:0] wordQ, wordD;
  logic [1:0]  idxQ, idxD;
  logic        errQ, errD;
`ifdef SPM_DUMP_CHECKSUM_EN
  logic [31:0] csumQ, csumD;
`endif

  logic [32:0] endCheck;
  logic        outValid;
  logic        fire;
  logic        unusedAddrBits;

  // Byte offset within the word is meaningless for a word sweep.
  assign unusedAddrBits = ^io_baseAddress[1:0];

  assign endCheck = {3'b000, io_baseAddress[31:2]} + {1'b0, io_wordCount};

`ifdef SPM_DUMP_CHECKSUM_EN
  assign outValid = (stateQ == StSend) || (stateQ == StCsum);
`else
  assign outValid = (stateQ == StSend);
`endif
  assign fire = outValid && io_out_ready;

  always_comb begin
    stateD = stateQ;
    addrD  = addrQ;
    remD   = remQ;
    wordD  = wordQ;
    idxD   = idxQ;
    errD   = errQ;
`ifdef SPM_DUMP_CHECKSUM_EN
    csumD  = csumQ;
`endif
    case (stateQ)
      StIdle: begin
        if (io_start) begin
          addrD = {io_baseAddress[31:2], 2'b00};
          remD  = io_wordCount;
          idxD  = 2'd0;
          errD  = 1'b0;
`ifdef SPM_DUMP_CHECKSUM_EN
          csumD = 32'd0;
`endif
          if (endCheck > 33'(WORDS)) begin
            errD   = 1'b1;
            stateD = StDone;
          end else if (io_wordCount == 32'd0) begin
`ifdef SPM_DUMP_CHECKSUM_EN
            stateD = StCsum;
`else
            stateD = StDone;
`endif
          end else begin
            stateD = StAddr;
          end
        end
      end
      StAddr: stateD = StLatch;
      StLatch: begin
        wordD  = io_rdData;
        remD   = remQ - 32'd1;
        idxD   = 2'd0;
`ifdef SPM_DUMP_CHECKSUM_EN
        csumD  = csumQ + io_rdData;
`endif
        stateD = StSend;
      end
      StSend: begin
        if (fire) begin
          idxD = idxQ + 2'd1;
          if (idxQ == 2'd3) begin
            if (remQ != 32'd0) begin
              addrD  = addrQ + 32'd4;
              stateD = StAddr;
            end else begin
`ifdef SPM_DUMP_CHECKSUM_EN
              stateD = StCsum;
`else
              stateD = StDone;
`endif
            end
          end
        end
      end
`ifdef SPM_DUMP_CHECKSUM_EN
      StCsum: begin
        if (fire) begin
          idxD = idxQ + 2'd1;
          if (idxQ == 2'd3) stateD = StDone;
        end
      end
`endif
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stateQ  <= StIdle;
      addrQ   <= 32'd0;
      rdAddrQ <= 32'd0;
      remQ    <= 32'd0;
      wordQ   <= 32'd0;
      idxQ    <= 2'd0;
      errQ    <= 1'b0;
`ifdef SPM_DUMP_CHECKSUM_EN
      csumQ   <= 32'd0;
`endif
    end else begin
      stateQ <= stateD;
      addrQ  <= addrD;
      remQ   <= remD;
      wordQ  <= wordD;
      idxQ   <= idxD;
      errQ   <= errD;
`ifdef SPM_DUMP_CHECKSUM_EN
      csumQ  <= csumD;
`endif
      // Read address only moves when a read is actually issued.
      if (stateD == StAddr) rdAddrQ <= addrD;
    end
  end

  always_comb begin
    io_out_bits = 8'h00;
    case (stateQ)
      StSend: io_out_bits = wordQ[{idxQ, 3'b000} +: 8];
`ifdef SPM_DUMP_CHECKSUM_EN
      StCsum: io_out_bits = csumQ[{idxQ, 3'b000} +: 8];
`endif
      default: io_out_bits = 8'h00;
    endcase
  end

  assign io_rdAddress = rdAddrQ;
  assign io_out_valid = outValid;
  assign io_busy      = (stateQ != StIdle);
  assign io_done      = (stateQ == StDone);
  assign io_error     = (stateQ == StDone) && errQ;

endmodule

// File: tb/tb_spm_dump_engine.sv
// Directed bench for spm_dump_engine; honours SPM_DUMP_CHECKSUM_EN to pick expected streams.
module tb_spm_dump_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_start = 1'b0;
  logic [31:0] io_baseAddress = 32'd0;
  logic [31:0] io_wordCount = 32'd0;
  logic [31:0] io_rdAddress;
  logic [31:0] io_rdData = 32'd0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [7:0]  io_out_bits;
  logic        io_busy;
  logic        io_done;
  logic        io_error;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:4095];
  logic [7:0]  gotQ[$];
  logic [7:0]  expQ[$];

  spm_dump_engine #(.WORDS(4096)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_start      (io_start),
    .io_baseAddress(io_baseAddress),
    .io_wordCount  (io_wordCount),
    .io_rdAddress  (io_rdAddress),
    .io_rdData     (io_rdData),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_bits   (io_out_bits),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_error      (io_error)
  );

  always #5 clock = ~clock;

  // Synchronous-read scratchpad model.
  always @(posedge clock) io_rdData <= mem[io_rdAddress[13:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic startDump(input logic [31:0] base, input logic [31:0] cnt);
    @(posedge clock); #1;
    io_baseAddress = base;
    io_wordCount   = cnt;
    io_start       = 1'b1;
    @(posedge clock); #1;
    io_start = 1'b0;
  endtask

  // Called at cycle 1; mode 0 = ready high, mode 1 = ready toggling.
  task automatic runDump(input int mode, input int pulseCyc, output int doneCyc,
                         output logic errAt);
    logic       prevStall;
    logic [7:0] prevBits;
    gotQ.delete();
    doneCyc   = -1;
    errAt     = 1'b0;
    prevStall = 1'b0;
    prevBits  = 8'h00;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      io_out_ready = (mode == 0) ? 1'b1 : cyc[0];
      io_start     = (cyc == pulseCyc);
      if (cyc == pulseCyc) io_baseAddress = 32'h100;
      if (prevStall) begin
        check("stall_valid", 32'(io_out_valid), 32'd1);
        check("stall_bits", 32'(io_out_bits), 32'(prevBits));
      end
      prevStall = io_out_valid && !io_out_ready;
      prevBits  = io_out_bits;
      if (io_out_valid && io_out_ready) gotQ.push_back(io_out_bits);
      if (io_done) begin
        doneCyc = cyc;
        errAt   = io_error;
        check("busy_in_done", 32'(io_busy), 32'd1);
        break;
      end
      @(posedge clock); #1;
    end
    io_start     = 1'b0;
    io_out_ready = 1'b1;
  endtask

  task automatic cmpBytes(input string tag);
    check({tag, "_len"}, 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      check({tag, "_byte"}, 32'(gotQ[i]), 32'(expQ[i]));
  endtask

  initial begin
    int   doneCyc;
    logic errAt;
    logic [31:0] lastRd;
`ifdef SPM_DUMP_CHECKSUM_EN
    int   csumOn = 1;
`else
    int   csumOn = 0;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[0] = 32'h44332211;
    mem[1] = 32'hDDCCBBAA;
    mem[2] = 32'h87654321;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_rdAddress", io_rdAddress, 32'd0);
    check("rst_valid", 32'(io_out_valid), 32'd0);
    check("rst_bits", 32'(io_out_bits), 32'd0);
    check("rst_busy", 32'(io_busy), 32'd0);
    check("rst_done", 32'(io_done), 32'd0);
    check("rst_error", 32'(io_error), 32'd0);
    reset = 1'b1;

    // Two words, ready high; checksum 0x44332211+0xDDCCBBAA = 0x21FFDDBB mod 2^32
    expQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    if (csumOn != 0) begin
      expQ.push_back(8'hBB); expQ.push_back(8'hDD);
      expQ.push_back(8'hFF); expQ.push_back(8'h21);
    end
    startDump(32'h0, 32'd2);
    check("busy_cycle1", 32'(io_busy), 32'd1);
    check("rdaddr_cycle1", io_rdAddress, 32'h0);
    runDump(0, 0, doneCyc, errAt);
    cmpBytes("two_words");
    check("two_words_done_cyc", 32'(doneCyc), (csumOn != 0) ? 32'd17 : 32'd13);
    check("two_words_err", 32'(errAt), 32'd0);

    // Same dump with ready toggling
    startDump(32'h0, 32'd2);
    runDump(1, 0, doneCyc, errAt);
    cmpBytes("toggle");
    check("toggle_done_seen", 32'(doneCyc > 0), 32'd1);

    // Start re-pulsed mid-dump is ignored
    startDump(32'h0, 32'd2);
    runDump(0, 4, doneCyc, errAt);
    cmpBytes("repulse");
    check("repulse_done_cyc", 32'(doneCyc), (csumOn != 0) ? 32'd17 : 32'd13);

    // Range error: 0xFFF + 2 > 4096
    lastRd = io_rdAddress;
    startDump(32'h3FFC, 32'd2);
    runDump(0, 0, doneCyc, errAt);
    check("err_done_cyc", 32'(doneCyc), 32'd1);
    check("err_flag", 32'(errAt), 32'd1);
    check("err_no_bytes", 32'(gotQ.size()), 32'd0);
    check("err_no_read", io_rdAddress, lastRd);

    // Zero count
    expQ.delete();
    if (csumOn != 0) expQ = '{8'h00, 8'h00, 8'h00, 8'h00};
    startDump(32'h0, 32'd0);
    runDump(0, 0, doneCyc, errAt);
    cmpBytes("zero");
    check("zero_done_cyc", 32'(doneCyc), (csumOn != 0) ? 32'd5 : 32'd1);
    check("zero_err", 32'(errAt), 32'd0);

    // Reset during SEND of the second word, then a clean dump from a new base
    startDump(32'h0, 32'd2);
    repeat (9) @(posedge clock);
    #1;
    check("pre_reset_valid", 32'(io_out_valid), 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    check("mid_rst_valid", 32'(io_out_valid), 32'd0);
    check("mid_rst_busy", 32'(io_busy), 32'd0);
    check("mid_rst_done", 32'(io_done), 32'd0);
    check("mid_rst_rdAddress", io_rdAddress, 32'd0);
    check("mid_rst_bits", 32'(io_out_bits), 32'd0);
    reset = 1'b1;
    expQ = '{8'h21, 8'h43, 8'h65, 8'h87};
    if (csumOn != 0) begin
      expQ.push_back(8'h21); expQ.push_back(8'h43);
      expQ.push_back(8'h65); expQ.push_back(8'h87);
    end
    startDump(32'h8, 32'd1);
    check("post_rst_rdaddr", io_rdAddress, 32'h8);
    runDump(0, 0, doneCyc, errAt);
    cmpBytes("post_rst");
    check("post_rst_done_cyc", 32'(doneCyc), (csumOn != 0) ? 32'd11 : 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
